fetch_queue_unit: RTL

// - Instruction fetch front end with a parametrised fetch queue between fetch and decode.
// - Fetch keeps running while decode is stalled, until the queue is full.
// - Sources instructions from the icache (hit path) or the memory controller (miss path).
// - Predicts JAL as taken and BR via the predictor; redirects on clr_in from the ROB.
// - A memory request still in flight when a flush arrives is drained and its data discarded.

---
 rtl/fetch_queue_unit_pkg.sv | 24 ++
 rtl/fetch_queue_unit_if.sv | 46 ++++
 rtl/fetch_queue_unit_fetch_queue.sv | 55 +++++
 rtl/fetch_queue_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared definitions for the fetch front end: opcodes, field ranges, default widths, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_queue_unit_pkg;

   localparam int ADDR_TYPE_W  = 32;
   localparam int INST_TYPE_W  = 32;
   localparam int FQ_DEPTH_DEF = 4;

   // Opcode field of an instruction word
   localparam int OPTYPE_HI = 6;
   localparam int OPTYPE_LO = 0;
   localparam int OPTYPE_W  = OPTYPE_HI - OPTYPE_LO + 1;

   localparam logic [OPTYPE_W-1:0] OP_JAL = 7'b1101111;
   localparam logic [OPTYPE_W-1:0] OP_BR  = 7'b1100011;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Bundle of fetch-unit control, memory, icache, predictor and decode signals.
// Latency: n/a (wires only).
// Backpressure: dc_valid/dc_accept toward decode; mc_req_valid held until mc_resp_valid.
// Ports: master = fetch unit side, slave = environment (ROB, memory, icache, predictor, decoder).
interface fetch_queue_unit_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = 3
);
   logic              rdy_in;
   logic              clr_in;
   logic [ADDR_W-1:0] redirect_pc;
   logic              mc_req_valid;
   logic [ADDR_W-1:0] mc_req_addr;
   logic              mc_resp_valid;
   logic [INST_W-1:0] mc_resp_inst;
   logic [ADDR_W-1:0] ic_fetch_addr;
   logic              ic_hit;
   logic [INST_W-1:0] ic_hit_inst;
   logic              ic_upd_valid;
   logic [ADDR_W-1:0] ic_upd_addr;
   logic [INST_W-1:0] ic_upd_inst;
   logic [ADDR_W-1:0] pr_pc;
   logic              pr_taken;
   logic              dc_valid;
   logic              dc_accept;
   logic [ADDR_W-1:0] dc_pc;
   logic [INST_W-1:0] dc_inst;
   logic [6:0]        dc_op;
   logic              dc_pred_br;
   logic [CNT_W-1:0]  fq_count;

   modport master (
      input  rdy_in, clr_in, redirect_pc, mc_resp_valid, mc_resp_inst,
             ic_hit, ic_hit_inst, pr_taken, dc_accept,
      output mc_req_valid, mc_req_addr, ic_fetch_addr, ic_upd_valid, ic_upd_addr,
             ic_upd_inst, pr_pc, dc_valid, dc_pc, dc_inst, dc_op, dc_pred_br, fq_count
   );

   modport slave (
      output rdy_in, clr_in, redirect_pc, mc_resp_valid, mc_resp_inst,
             ic_hit, ic_hit_inst, pr_taken, dc_accept,
      input  mc_req_valid, mc_req_addr, ic_fetch_addr, ic_upd_valid, ic_upd_addr,
             ic_upd_inst, pr_pc, dc_valid, dc_pc, dc_inst, dc_op, dc_pred_br, fq_count
   );
endinterface

// File: rtl/fetch_queue_unit_fetch_queue.sv
// Synchronous FIFO of fetched entries {pc, inst, pred}; head is a registered entry.
// Latency: a push is visible at the head one cycle later; pop takes effect at the clock edge.
// Backpressure: caller must not push when full nor pop when empty; flush empties in one cycle.
// Ports: clk/rst, push/push_data, pop, flush, head_data, count, full, empty.
module fetch_queue
   import fetch_queue_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);   // DEPTH is a power of two, so this wraps
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];
   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: icache hit / memory miss sourcing, JAL/BR prediction, fetch queue.
// Latency: icache hit enters the queue at the next edge (1 inst/cycle); miss waits for mc_resp_valid.
// Backpressure: fetch stops while the queue is full; decode pops with dc_valid & dc_accept.
// Ports: clk_in, rst_in (async active-high), bus = fetch_queue_unit_if.master.
module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_TYPE_W,
   parameter int                INST_W   = INST_TYPE_W,
   parameter int                FQ_DEPTH = FQ_DEPTH_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk_in,
   input  logic               rst_in,
   fetch_queue_unit_if.master bus
);
   localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
   localparam int ENT_W = ADDR_W + INST_W + 1;

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic              req, req_n;
   logic              push, pop, flush, fill;
   logic              full, empty;
   logic [CNT_W-1:0]  count;
   logic [ENT_W-1:0]  head;
   logic [INST_W-1:0] head_inst;
   logic [INST_W-1:0] cur_inst;
   logic              is_jal, is_br, pred;
   logic [ADDR_W-1:0] j_imm, b_imm, next_pc;

   // The instruction being fetched this cycle comes from memory only while a miss is pending
   assign cur_inst = (state == MEM_WAIT) ? bus.mc_resp_inst : bus.ic_hit_inst;
   assign is_jal   = (cur_inst[OPTYPE_HI:OPTYPE_LO] == OP_JAL);
   assign is_br    = (cur_inst[OPTYPE_HI:OPTYPE_LO] == OP_BR);
   assign pred     = is_jal | (is_br & bus.pr_taken);

   assign j_imm = {{(ADDR_W-20){cur_inst[31]}}, cur_inst[19:12], cur_inst[20], cur_inst[30:21], 1'b0};
   assign b_imm = {{(ADDR_W-12){cur_inst[31]}}, cur_inst[7], cur_inst[30:25], cur_inst[11:8], 1'b0};

   always_comb begin
      next_pc = pc + ADDR_W'(4);
      if (is_jal)                     next_pc = pc + j_imm;
      else if (is_br && bus.pr_taken) next_pc = pc + b_imm;
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      req_n   = req;
      push    = 1'b0;
      flush   = 1'b0;
      fill    = 1'b0;
      if (bus.rdy_in) begin
         if (bus.clr_in) begin
            flush = 1'b1;
            pc_n  = bus.redirect_pc;
            req_n = 1'b0;
            // An outstanding request must be drained, unless its response lands in this very cycle
            if ((state == MEM_WAIT || state == DRAIN) && !bus.mc_resp_valid) state_n = DRAIN;
            else                                                               state_n = IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (!full) begin
                     if (bus.ic_hit) begin
                        push = 1'b1;
                        pc_n = next_pc;
                     end else begin
                        req_n   = 1'b1;
                        state_n = MEM_WAIT;
                     end
                  end
               end
               MEM_WAIT: begin
                  // Slot is guaranteed: the miss was issued when not full and nothing else pushes
                  if (bus.mc_resp_valid) begin
                     push    = 1'b1;
                     fill    = 1'b1;
                     pc_n    = next_pc;
                     req_n   = 1'b0;
                     state_n = IDLE;
                  end
               end
               DRAIN: begin
                  if (bus.mc_resp_valid) state_n = IDLE;
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

   assign pop = bus.rdy_in && !bus.clr_in && !empty && bus.dc_accept;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
         pc    <= RESET_PC;
         req   <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         req   <= req_n;
      end
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH),
      .WIDTH (ENT_W)
   ) u_fetch_queue (
      .clk       (clk_in),
      .rst       (rst_in),
      .push      (push),
      .push_data ({pc, cur_inst, pred}),
      .pop       (pop),
      .flush     (flush),
      .head_data (head),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // PC is stable for the whole miss, so the request address can be taken from it directly
   assign bus.mc_req_valid  = req;
   assign bus.mc_req_addr   = req ? pc : '0;
   assign bus.ic_fetch_addr = pc;
   assign bus.pr_pc         = pc;
   assign bus.ic_upd_valid  = fill;
   assign bus.ic_upd_addr   = fill ? pc : '0;
   assign bus.ic_upd_inst   = fill ? bus.mc_resp_inst : '0;

   assign head_inst      = head[INST_W:1];
   assign bus.dc_valid   = !empty;
   assign bus.dc_pc      = head[ENT_W-1:INST_W+1];
   assign bus.dc_inst    = head_inst;
   assign bus.dc_op      = head_inst[OPTYPE_HI:OPTYPE_LO];
   assign bus.dc_pred_br = head[0];
   assign bus.fq_count   = count;
endmodule
